// File: rtl/mod_147_11_link_mon.sv
// Link status monitor: derives pcs_status from HEARTBEAT/RX_DV activity with
// hysteresis counters, a hold timer, a latching-low status copy and link event pulses.
module mod_147_11_link_mon #(
    parameter int CNT_W       = 8,
    parameter int TMR_W       = 20,
    parameter int HOLD_CYCLES = 500000,
    parameter int EVT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pcs_reset,
    input  logic             mr_autoneg_enable,
    input  logic             an_link_good,
    input  logic             multidrop,
    input  logic [1:0]       rx_cmd,
    input  logic             RX_DV,
    input  logic             CRS,
    input  logic [CNT_W-1:0] ACTIVE_CNT,
    input  logic [CNT_W-1:0] INACTIVE_CNT,
    input  logic             status_rd,
    output logic [2:0]       mod_147_11_state,
    output logic             pcs_status,
    output logic             pcs_status_ll,
    output logic             link_up,
    output logic             link_down,
    output logic [EVT_W-1:0] link_evt_cnt,
    output logic [CNT_W-1:0] cnt_h,
    output logic [CNT_W-1:0] cnt_l
);

    localparam logic [2:0] S_INACTIVE   = 3'd0;
    localparam logic [2:0] S_COUNT_DOWN = 3'd1;
    localparam logic [2:0] S_COUNT_UP   = 3'd2;
    localparam logic [2:0] S_HOLD_OFF   = 3'd3;
    localparam logic [2:0] S_ACTIVE     = 3'd4;
    localparam logic [2:0] S_HOLD_ON    = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [EVT_W-1:0] EVT_MAX  = {EVT_W{1'b1}};
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_h_reg, cnt_h_next;
    logic [CNT_W-1:0] cnt_l_reg, cnt_l_next;
    logic             status_reg, status_next;
    logic             timer_restart;
    logic [TMR_W-1:0] timer_reg;
    logic             status_d_reg;
    logic             link_up_reg, link_down_reg;
    logic             ll_reg;
    logic [EVT_W-1:0] evt_reg;

    logic hb, idle, force_inactive, timer_done, entering, up_det, down_det;

    assign hb             = (rx_cmd == 2'b10) | RX_DV;
    assign idle           = (rx_cmd == 2'b11) & ~RX_DV;
    assign force_inactive = pcs_reset | ~mr_autoneg_enable | ~an_link_good | multidrop;
    assign timer_done     = (timer_reg == '0);
    assign up_det         = ~status_d_reg & status_reg;
    assign down_det       = status_d_reg & ~status_reg;

    // State and entry-action registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_INACTIVE;
            cnt_h_reg  <= '0;
            cnt_l_reg  <= '0;
            status_reg <= 1'b0;
            timer_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_h_reg  <= cnt_h_next;
            cnt_l_reg  <= cnt_l_next;
            status_reg <= status_next;
            if (timer_restart)
                timer_reg <= TMR_LOAD;
            else if (!timer_done)
                timer_reg <= timer_reg - 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (force_inactive) begin
            state_next = S_INACTIVE;
        end else begin
            case (state_reg)
                S_INACTIVE:   if (hb) state_next = S_COUNT_UP;
                S_COUNT_UP: begin
                    if (cnt_h_reg == ACTIVE_CNT)
                        state_next = S_ACTIVE;
                    else if (idle && !CRS && (cnt_h_reg < ACTIVE_CNT))
                        state_next = S_HOLD_OFF;
                end
                S_HOLD_OFF: begin
                    if (hb)
                        state_next = S_COUNT_UP;
                    else if (timer_done && idle)
                        state_next = S_INACTIVE;
                end
                S_ACTIVE: begin
                    if (hb)
                        state_next = S_HOLD_ON;
                    else if (timer_done)
                        state_next = S_COUNT_DOWN;
                end
                S_HOLD_ON:    if (idle) state_next = S_ACTIVE;
                S_COUNT_DOWN: state_next = (cnt_l_reg == INACTIVE_CNT) ? S_INACTIVE : S_ACTIVE;
                default:      state_next = S_INACTIVE;
            endcase
        end
    end

    // Entry actions fire only on an actual state change; INACTIVE's are idempotent.
    assign entering = (state_next != state_reg);

    always_comb begin
        cnt_h_next    = cnt_h_reg;
        cnt_l_next    = cnt_l_reg;
        status_next   = status_reg;
        timer_restart = 1'b0;
        case (state_next)
            S_INACTIVE: begin
                status_next = 1'b0;
                cnt_h_next  = '0;
                cnt_l_next  = '0;
            end
            S_COUNT_UP: if (entering) begin
                cnt_h_next    = (cnt_h_reg == CNT_MAX) ? cnt_h_reg : cnt_h_reg + 1'b1;
                timer_restart = 1'b1;
            end
            S_ACTIVE: if (entering) begin
                status_next   = 1'b1;
                timer_restart = 1'b1;
            end
            S_HOLD_ON:    if (entering) cnt_l_next = '0;
            S_COUNT_DOWN: if (entering)
                cnt_l_next = (cnt_l_reg == CNT_MAX) ? cnt_l_reg : cnt_l_reg + 1'b1;
            default: ;
        endcase
    end

    // Link event pulses lag pcs_status by one clock; a link drop beats a read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_d_reg  <= 1'b0;
            link_up_reg   <= 1'b0;
            link_down_reg <= 1'b0;
            ll_reg        <= 1'b0;
            evt_reg       <= '0;
        end else begin
            status_d_reg  <= status_reg;
            link_up_reg   <= up_det;
            link_down_reg <= down_det;
            if (down_det)
                ll_reg <= 1'b0;
            else if (status_rd)
                ll_reg <= status_reg;
            if (down_det)
                evt_reg <= status_rd ? EVT_W'(1) : ((evt_reg == EVT_MAX) ? evt_reg : evt_reg + 1'b1);
            else if (status_rd)
                evt_reg <= '0;
        end
    end

    assign mod_147_11_state = state_reg;
    assign pcs_status       = status_reg;
    assign pcs_status_ll    = ll_reg;
    assign link_up          = link_up_reg;
    assign link_down        = link_down_reg;
    assign link_evt_cnt     = evt_reg;
    assign cnt_h            = cnt_h_reg;
    assign cnt_l            = cnt_l_reg;

endmodule

// File: tb/tb_mod_147_11_link_mon.sv
// Scoreboard bench for mod_147_11_link_mon: a behavioural model predicts every
// post-edge output set, a monitor compares the DUT against the queued predictions.
module tb_mod_147_11_link_mon;

    localparam int CNT_W = 8;
    localparam int TMR_W = 8;
    localparam int HOLD  = 8;
    localparam int EVT_W = 8;
    localparam int CMAX  = 255;
    localparam int EMAX  = 255;

    localparam int ST_INACT = 0;
    localparam int ST_CD    = 1;
    localparam int ST_CU    = 2;
    localparam int ST_HOFF  = 3;
    localparam int ST_ACT   = 4;
    localparam int ST_HON   = 5;

    localparam logic [1:0] BEACON = 2'b00;
    localparam logic [1:0] COMMIT = 2'b01;
    localparam logic [1:0] HBEAT  = 2'b10;
    localparam logic [1:0] NONE   = 2'b11;

    logic             clk;
    logic             reset_n;
    logic             pcs_reset, mr_autoneg_enable, an_link_good, multidrop;
    logic [1:0]       rx_cmd;
    logic             RX_DV, CRS, status_rd;
    logic [CNT_W-1:0] act_cnt, inact_cnt;
    logic [2:0]       dut_state;
    logic             pcs_status, pcs_status_ll, link_up, link_down;
    logic [EVT_W-1:0] link_evt_cnt;
    logic [CNT_W-1:0] cnt_h, cnt_l;

    mod_147_11_link_mon #(
        .CNT_W(CNT_W), .TMR_W(TMR_W), .HOLD_CYCLES(HOLD), .EVT_W(EVT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pcs_reset(pcs_reset),
        .mr_autoneg_enable(mr_autoneg_enable), .an_link_good(an_link_good),
        .multidrop(multidrop), .rx_cmd(rx_cmd), .RX_DV(RX_DV), .CRS(CRS),
        .ACTIVE_CNT(act_cnt), .INACTIVE_CNT(inact_cnt), .status_rd(status_rd),
        .mod_147_11_state(dut_state), .pcs_status(pcs_status),
        .pcs_status_ll(pcs_status_ll), .link_up(link_up), .link_down(link_down),
        .link_evt_cnt(link_evt_cnt), .cnt_h(cnt_h), .cnt_l(cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st; bit ok; bit ll; bit up; bit dn; int evt; int ch; int cl;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: the hold timer is kept as the edge index of its last restart.
    int m_st = 0, m_ch = 0, m_cl = 0, m_evt = 0;
    bit m_ok = 0, m_ll = 0, m_up = 0, m_dn = 0, m_prev = 0;
    int m_cyc = 0, m_restart = -HOLD;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_step();
        bit hb, idle, frc, done, restart, nd, nu;
        int ns;
        if (!reset_n) begin
            m_st = ST_INACT; m_ok = 0; m_ll = 0; m_up = 0; m_dn = 0;
            m_evt = 0; m_ch = 0; m_cl = 0; m_prev = 0;
            m_cyc++;
            m_restart = m_cyc - HOLD;
        end else begin
            hb   = (rx_cmd == HBEAT) || RX_DV;
            idle = (rx_cmd == NONE) && !RX_DV;
            frc  = pcs_reset || !mr_autoneg_enable || !an_link_good || multidrop;
            done = (m_cyc - m_restart) >= HOLD - 1;
            ns = m_st;
            if (frc) ns = ST_INACT;
            else if (m_st == ST_INACT && hb) ns = ST_CU;
            else if (m_st == ST_CU && m_ch == int'(act_cnt)) ns = ST_ACT;
            else if (m_st == ST_CU && idle && !CRS && m_ch < int'(act_cnt)) ns = ST_HOFF;
            else if (m_st == ST_HOFF && hb) ns = ST_CU;
            else if (m_st == ST_HOFF && done && idle) ns = ST_INACT;
            else if (m_st == ST_ACT && hb) ns = ST_HON;
            else if (m_st == ST_ACT && done) ns = ST_CD;
            else if (m_st == ST_HON && idle) ns = ST_ACT;
            else if (m_st == ST_CD) ns = (m_cl == int'(inact_cnt)) ? ST_INACT : ST_ACT;

            nd = m_prev && !m_ok;
            nu = !m_prev && m_ok;
            m_prev = m_ok;
            if (nd) m_evt = status_rd ? 1 : ((m_evt + 1 > EMAX) ? EMAX : m_evt + 1);
            else if (status_rd) m_evt = 0;
            if (nd) m_ll = 0;
            else if (status_rd) m_ll = m_ok;
            m_up = nu;
            m_dn = nd;

            restart = 0;
            if (ns == ST_INACT) begin
                m_ok = 0; m_ch = 0; m_cl = 0;
            end else if (ns != m_st) begin
                if (ns == ST_CU) begin m_ch = (m_ch + 1 > CMAX) ? CMAX : m_ch + 1; restart = 1; end
                if (ns == ST_ACT) begin m_ok = 1; restart = 1; end
                if (ns == ST_HON) m_cl = 0;
                if (ns == ST_CD) m_cl = (m_cl + 1 > CMAX) ? CMAX : m_cl + 1;
            end
            m_st = ns;
            m_cyc++;
            if (restart) m_restart = m_cyc;
        end
        sb_q.push_back('{st: m_st, ok: m_ok, ll: m_ll, up: m_up, dn: m_dn,
                         evt: m_evt, ch: m_ch, cl: m_cl});
    endtask

    // Inputs change at negedge; the prediction is queued before the next posedge.
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int bound, input string name);
        for (int i = 0; i < bound && m_st != s; i++) tick();
        chk(name, int'(dut_state), s);
    endtask

    task automatic go_active();
        for (int i = 0; i < 200 && m_st != ST_ACT; i++) begin
            rx_cmd = (i % 4 == 0) ? HBEAT : NONE;
            tick();
        end
        rx_cmd = NONE;
        chk("go_active", int'(dut_state), ST_ACT);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if (int'(dut_state) == mon_e.st && pcs_status == mon_e.ok && pcs_status_ll == mon_e.ll &&
                link_up == mon_e.up && link_down == mon_e.dn && int'(link_evt_cnt) == mon_e.evt &&
                int'(cnt_h) == mon_e.ch && int'(cnt_l) == mon_e.cl)
                n_pass++;
            else
                $display("FAIL cycle %0t: got st=%0d ok=%0d ll=%0d up=%0d dn=%0d evt=%0d ch=%0d cl=%0d, expected st=%0d ok=%0d ll=%0d up=%0d dn=%0d evt=%0d ch=%0d cl=%0d",
                         $time, dut_state, pcs_status, pcs_status_ll, link_up, link_down, link_evt_cnt, cnt_h, cnt_l,
                         mon_e.st, mon_e.ok, mon_e.ll, mon_e.up, mon_e.dn, mon_e.evt, mon_e.ch, mon_e.cl);
        end
    end

    initial begin
        int r, hb_pct;
        reset_n = 0; pcs_reset = 0; mr_autoneg_enable = 1; an_link_good = 1; multidrop = 0;
        rx_cmd = NONE; RX_DV = 0; CRS = 0; status_rd = 0;
        act_cnt = 8'd3; inact_cnt = 8'd2;
        @(negedge clk);
        tick(); tick();
        chk("reset_state", int'(dut_state), ST_INACT);
        reset_n = 1;
        tick();

        // Heartbeat every 4 clocks brings the link up after three hits
        for (int k = 0; k < 3; k++) begin
            rx_cmd = HBEAT; tick();
            rx_cmd = NONE;  tick(); tick(); tick();
        end
        chk("up_state", int'(dut_state), ST_ACT);
        chk("up_status", int'(pcs_status), 1);
        for (int i = 0; i < 20; i++) tick();
        chk("down_state", int'(dut_state), ST_INACT);
        chk("down_evt", int'(link_evt_cnt), 1);

        // A heartbeat after the first expiry resets cnt_l; two more expiries drop the link
        go_active();
        wait_state(ST_CD, 20, "first_expiry");
        tick();
        chk("cnt_l_after_expiry", int'(cnt_l), 1);
        rx_cmd = HBEAT; tick();
        chk("hold_on_state", int'(dut_state), ST_HON);
        chk("hold_on_cnt_l", int'(cnt_l), 0);
        rx_cmd = NONE; tick();
        wait_state(ST_CD, 20, "second_expiry");
        tick();
        chk("still_active", int'(dut_state), ST_ACT);
        wait_state(ST_CD, 20, "third_expiry");
        tick();
        chk("dropped", int'(dut_state), ST_INACT);

        // HOLD_OFF timing out returns to INACTIVE; carrier keeps COUNT_UP
        rx_cmd = HBEAT; tick();
        rx_cmd = NONE;
        for (int i = 0; i < 8; i++) tick();
        chk("hold_off_timeout", int'(dut_state), ST_INACT);
        chk("hold_off_cnt_h", int'(cnt_h), 0);
        CRS = 1;
        rx_cmd = HBEAT; tick();
        rx_cmd = NONE; tick(); tick(); tick();
        chk("crs_count_up", int'(dut_state), ST_CU);
        CRS = 0;
        for (int i = 0; i < 10; i++) tick();

        // Multidrop forces INACTIVE; latch stays low until a read with the link up
        go_active();
        status_rd = 1; tick(); status_rd = 0;
        chk("ll_set", int'(pcs_status_ll), 1);
        multidrop = 1; tick(); multidrop = 0;
        chk("multidrop_state", int'(dut_state), ST_INACT);
        tick();
        chk("ll_cleared", int'(pcs_status_ll), 0);
        go_active();
        chk("ll_still_low", int'(pcs_status_ll), 0);
        status_rd = 1; tick(); status_rd = 0;
        chk("ll_rearmed", int'(pcs_status_ll), 1);

        // Randomised traffic with alternating heartbeat density
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                act_cnt   = 8'($urandom_range(0, 4));
                inact_cnt = 8'($urandom_range(0, 3));
            end
            hb_pct = ((i / 250) % 2 == 1) ? 10 : 40;
            r = $urandom_range(0, 99);
            rx_cmd = (r < hb_pct) ? HBEAT : (r < hb_pct + 5) ? BEACON : (r < hb_pct + 10) ? COMMIT : NONE;
            RX_DV             = ($urandom_range(0, 99) < 6);
            CRS               = ($urandom_range(0, 99) < 25);
            status_rd         = ($urandom_range(0, 99) < 6);
            pcs_reset         = ($urandom_range(0, 199) < 2);
            mr_autoneg_enable = !($urandom_range(0, 199) < 1);
            an_link_good      = !($urandom_range(0, 199) < 2);
            multidrop         = ($urandom_range(0, 199) < 1);
            tick();
        end
        rx_cmd = NONE; RX_DV = 0; CRS = 0; status_rd = 0;
        pcs_reset = 0; mr_autoneg_enable = 1; an_link_good = 1; multidrop = 0;
        act_cnt = 8'd3; inact_cnt = 8'd3;
        for (int i = 0; i < 30; i++) tick();

        // Asynchronous reset while in COUNT_DOWN
        status_rd = 1; tick(); status_rd = 0;
        go_active();
        wait_state(ST_CD, 30, "reach_count_down");
        reset_n = 0;
        #1;
        chk("async_state", int'(dut_state), ST_INACT);
        chk("async_status", int'(pcs_status), 0);
        chk("async_cnt_l", int'(cnt_l), 0);
        chk("async_cnt_h", int'(cnt_h), 0);
        tick();
        reset_n = 1;
        tick();

        // Event counter saturation: ACTIVE_CNT=1 with constant heartbeat, multidrop pulses
        act_cnt = 8'd1;
        rx_cmd = HBEAT;
        for (int k = 0; k < 300; k++) begin
            tick(); tick();
            multidrop = 1; tick(); multidrop = 0;
        end
        tick(); tick();
        chk("evt_saturated", int'(link_evt_cnt), EMAX);
        status_rd = 1; tick(); status_rd = 0;
        chk("evt_cleared", int'(link_evt_cnt), 0);
        tick();

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
